// File: rtl/pci_arbiter.sv
// pci_arbiter: four-master PCI bus arbiter.
// Round-robin grant selection, grant revocation on FRAME# timeout,
// preemption of a running transaction when another master requests,
// and a guaranteed all-high gnt_n clock between successive grants.
//
// Handshake contract: a master that sees its gnt_n bit low while the
// bus is idle starts a transaction by pulling FRAME# low; the arbiter
// keeps the grant until the owner withdraws its request, times out, or
// (once the transaction runs) another master asks for the bus, and it
// only hands the bus on after FRAME#/IRDY# both return high.
//
// The FSM state lives in the register named 'state' (IDLE/GRANT/BUSY)
// so checkers can bind to it directly.
module pci_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_n,
  input  logic       frame,
  input  logic       irdy,
  output logic [3:0] gnt_n,
  output logic [1:0] owner,
  output logic       owner_valid,
  output logic       timeout_err
);

  // Wait counter width; a TIMEOUT of 1 still needs one bit of storage.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    last;

  logic          frame_hi;
  logic          irdy_hi;
  logic          bus_idle;
  logic          any_req;
  logic          others_req;
  logic [3:0]    owner_mask;
  logic [1:0]    winner;
  logic [1:0]    cand;
  logic          found;

  // The shared lines are pulled up on the board: anything that is not a
  // solid 0 (including a floating z or an unknown x) reads as deasserted.
  assign frame_hi   = (frame !== 1'b0);
  assign irdy_hi    = (irdy  !== 1'b0);
  assign bus_idle   = frame_hi & irdy_hi;
  assign any_req    = ~&req_n;
  assign owner_mask = 4'b0001 << owner;
  assign others_req = |(~req_n & ~owner_mask);

  // Round-robin pick: scan from last+1 upward, the previous owner is
  // looked at last so it loses whenever anyone else is requesting.
  always_comb begin
    winner = last;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!found && !req_n[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt_n       <= 4'b1111;
      owner       <= 2'd0;
      owner_valid <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
      last        <= 2'd3;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          // No parking: the grant only goes out on a request with the bus idle.
          if (bus_idle && any_req) begin
            gnt_n       <= ~(4'b0001 << winner);
            owner       <= winner;
            owner_valid <= 1'b1;
            cnt         <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (!frame_hi) begin
            // Owner started its transaction; keep the grant for now.
            cnt   <= '0;
            state <= BUSY;
          end else if (req_n[owner]) begin
            // Owner gave up before using the bus.
            gnt_n       <= 4'b1111;
            owner_valid <= 1'b0;
            cnt         <= '0;
            last        <= owner;
            state       <= IDLE;
          end else if (cnt == CNT_LAST) begin
            // Owner sat on the grant for TIMEOUT clocks without FRAME#.
            gnt_n       <= 4'b1111;
            owner_valid <= 1'b0;
            timeout_err <= 1'b1;
            cnt         <= '0;
            last        <= owner;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BUSY: begin
          if (bus_idle) begin
            // Transaction finished; IDLE adds the mandatory all-high clock.
            gnt_n       <= 4'b1111;
            owner_valid <= 1'b0;
            last        <= owner;
            state       <= IDLE;
          end else if (others_req) begin
            // Preempt: the owner finishes its current transaction but
            // must not start another one.
            gnt_n <= 4'b1111;
          end
        end
        default: begin
          gnt_n       <= 4'b1111;
          owner_valid <= 1'b0;
          cnt         <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_arbiter.sv
// tb_pci_arbiter: directed bench for pci_arbiter with a grant scoreboard.
// Inputs change on the falling clock edge, outputs are sampled there too.
module tb_pci_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_n;
  logic       frame;
  logic       irdy;
  logic [3:0] gnt_n;
  logic [1:0] owner;
  logic       owner_valid;
  logic       timeout_err;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];

  pci_arbiter #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_n       (req_n),
    .frame       (frame),
    .irdy        (irdy),
    .gnt_n       (gnt_n),
    .owner       (owner),
    .owner_valid (owner_valid),
    .timeout_err (timeout_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic push_gnt(input logic [3:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_gnt(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s got=%b exp=<empty queue>", tag, gnt_n);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(gnt_n), 32'(e));
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset(input logic [3:0] req);
    rst_n = 1'b0;
    frame = 1'b1;
    irdy  = 1'b1;
    req_n = req;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_bus(input logic busy);
    frame = ~busy;
    irdy  = ~busy;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         w;
    int         low;
    int         errs;
    logic [3:0] prev;
    logic [3:0] g;
    logic [3:0] rr_exp[5];

    // Reset values, and arbitration on the first edge after release.
    rst_n = 1'b0;
    req_n = 4'b0000;
    frame = 1'b1;
    irdy  = 1'b1;
    @(negedge clk);
    check("rst_gnt", 32'(gnt_n), 32'h f);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_valid", 32'(owner_valid), 32'h0);
    check("rst_terr", 32'(timeout_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    push_gnt(4'b1110);
    @(negedge clk);
    pop_gnt("first_grant");
    check("first_owner", 32'(owner), 32'h0);
    check("first_valid", 32'(owner_valid), 32'h1);

    // Withdrawal before FRAME#, then master 0 is lowest priority.
    req_n = 4'b1111;
    push_gnt(4'b1111);
    @(negedge clk);
    pop_gnt("withdraw0_gnt");
    check("withdraw0_valid", 32'(owner_valid), 32'h0);
    req_n = 4'b0000;
    push_gnt(4'b1101);
    @(negedge clk);
    pop_gnt("after_withdraw0_gnt");
    check("after_withdraw0_owner", 32'(owner), 32'h1);

    // Round robin with all four requesting, 3-clock transactions each.
    do_reset(4'b0000);
    rr_exp[0] = 4'b1110;
    rr_exp[1] = 4'b1101;
    rr_exp[2] = 4'b1011;
    rr_exp[3] = 4'b0111;
    rr_exp[4] = 4'b1110;
    for (int k = 0; k < 5; k++) push_gnt(rr_exp[k]);
    prev = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      @(negedge clk);
      while (gnt_n == 4'b1111 && w < 12) begin
        prev = gnt_n;
        @(negedge clk);
        w++;
      end
      check($sformatf("rr_latency_%0d", k), 32'(w), (k == 0) ? 32'd0 : 32'd1);
      check($sformatf("rr_gap_%0d", k), 32'(prev), 32'h f);
      pop_gnt($sformatf("rr_order_%0d", k));
      g = gnt_n;
      drive_bus(1'b1);
      @(negedge clk);
      check($sformatf("rr_busy_hold_%0d", k), 32'(gnt_n), 32'(g));
      @(negedge clk);
      check($sformatf("rr_preempt_%0d", k), 32'(gnt_n), 32'h f);
      @(negedge clk);
      drive_bus(1'b0);
      prev = gnt_n;
    end

    // Timeout: master 1 never drives FRAME#.
    do_reset(4'b1101);
    push_gnt(4'b1101);
    @(negedge clk);
    pop_gnt("to_grant");
    low  = 1;
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt_n[1]) break;
      low++;
      errs += int'(timeout_err);
    end
    check("to_low_clocks", 32'(low), 32'd16);
    check("to_err_early", 32'(errs), 32'd0);
    check("to_err_pulse", 32'(timeout_err), 32'h1);
    check("to_valid", 32'(owner_valid), 32'h0);
    push_gnt(4'b1111);
    pop_gnt("to_release");
    push_gnt(4'b1101);
    @(negedge clk);
    check("to_err_one_clock", 32'(timeout_err), 32'h0);
    pop_gnt("to_regrant");

    // Preemption of master 2 by master 0.
    do_reset(4'b1011);
    push_gnt(4'b1011);
    @(negedge clk);
    pop_gnt("pre_grant2");
    drive_bus(1'b1);
    push_gnt(4'b1011);
    @(negedge clk);
    pop_gnt("pre_busy_hold");
    req_n = 4'b1010;
    push_gnt(4'b1111);
    @(negedge clk);
    pop_gnt("pre_deassert");
    check("pre_owner", 32'(owner), 32'h2);
    check("pre_valid_busy", 32'(owner_valid), 32'h1);
    push_gnt(4'b1111);
    @(negedge clk);
    pop_gnt("pre_still_busy");
    drive_bus(1'b0);
    push_gnt(4'b1111);
    @(negedge clk);
    pop_gnt("pre_idle_gap");
    check("pre_valid_idle", 32'(owner_valid), 32'h0);
    push_gnt(4'b1110);
    @(negedge clk);
    pop_gnt("pre_grant0");
    check("pre_owner0", 32'(owner), 32'h0);

    // Master 3 withdraws before FRAME#.
    do_reset(4'b0111);
    push_gnt(4'b0111);
    @(negedge clk);
    pop_gnt("wd_grant3");
    req_n = 4'b1111;
    push_gnt(4'b1111);
    @(negedge clk);
    pop_gnt("wd_release");
    check("wd_no_terr", 32'(timeout_err), 32'h0);
    check("wd_valid", 32'(owner_valid), 32'h0);
    req_n = 4'b0000;
    push_gnt(4'b1110);
    @(negedge clk);
    pop_gnt("wd_next0");

    // Reset asserted mid-transaction.
    do_reset(4'b1110);
    push_gnt(4'b1110);
    @(negedge clk);
    pop_gnt("rb_grant0");
    drive_bus(1'b1);
    @(negedge clk);
    check("rb_busy_valid", 32'(owner_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    push_gnt(4'b1111);
    #1;
    pop_gnt("rb_async_gnt");
    check("rb_async_valid", 32'(owner_valid), 32'h0);
    check("rb_async_owner", 32'(owner), 32'h0);
    drive_bus(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
